frame_ram_writer: RTL and testbench
===================================

// Module: frame_ram_writer
// PURPOSE
//  Consumer end of the 128-bit game-mode frame bus (16 font bytes, MSB byte = cell 0).
//  Captures a stable snapshot of data_input whenever it differs from the last frame written.
//  Streams the snapshot byte-by-byte into the display RAM over a valid/ready write port.
//  Sits between the game-mode mux (high_or_low, etc.) and the display RAM/scan logic.
// PARAMETERS
//  NUM_BYTES    16     cells per frame; data_input width = NUM_BYTES*BYTE_W
//  BYTE_W       8      font code width
//  ADDR_W       4      wr_addr width; must satisfy 2**ADDR_W >= NUM_BYTES
//  REFRESH_CYC  0      forced full rewrite every REFRESH_CYC clk cycles; 0 = disabled
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  asynchronous reset, active low
//  data_input   in   NUM_BYTES*BYTE_W   frame from game mode; byte i = data_input[DW-1-8i -: 8]
//  wr_ready     in   1                  RAM accepts current write this cycle
//  wr_en        out  1                  write request valid
//  wr_addr      out  ADDR_W             cell index 0..NUM_BYTES-1
//  wr_data      out  BYTE_W             font code for wr_addr
//  busy         out  1                  a frame is being written
//  frame_done   out  1                  one-cycle pulse after last byte accepted
// BEHAVIOUR
//  Reset (async): wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, state=IDLE,
//   last_frame=0, dirty=1 (first frame after reset is always written, even if all-zero).
//  States: IDLE -> LOAD -> WRITE -> DONE -> IDLE.
//  IDLE: dirty=1 or data_input!=last_frame or refresh tick -> LOAD next cycle.
//  LOAD (1 cycle): snapshot<=data_input, last_frame<=data_input, dirty<=0, idx<=0, busy=1.
//  WRITE: wr_en=1, wr_addr=idx, wr_data=snapshot byte idx, all registered outputs.
//   Transfer occurs on a cycle where wr_en=1 and wr_ready=1; only then idx increments
//   and wr_addr/wr_data advance next cycle. wr_en/wr_addr/wr_data hold stable while
//   wr_ready=0 (no drop, no repeat). Transfer with idx=NUM_BYTES-1 -> DONE.
//  DONE (1 cycle): wr_en=0, frame_done=1, busy=0 from next cycle; -> IDLE.
//  Min latency: input change at cycle n -> first wr_en at n+2; full frame with
//   wr_ready tied high = NUM_BYTES+3 cycles from change to frame_done.
//  data_input change while busy: snapshot unaffected; the change is detected in IDLE
//   by comparison with last_frame, so at most one extra frame follows (latest value only).
//  Refresh tick (REFRESH_CYC>0): free-running counter, wraps to 0 at REFRESH_CYC-1 and sets dirty;
//   a tick while busy is held in dirty, never lost, never queued twice.
//  Simultaneous change + refresh tick: single rewrite.
//  Reset mid-frame: write aborted immediately, wr_en=0; full rewrite after release.
//  Unused addresses (>=NUM_BYTES) are never driven.
// STRUCTURE
//  Shared global.v: `FRAME_BYTES 16, `FONT_W 8, `FRAME_W 128 constants; reuse existing
//   FONT_* / FONT_NONE codes; state encodings local to this file.
//  Optional sub-module: refresh_timer (counter + tick pulse, generated only if REFRESH_CYC>0).
// TESTING
//  1 Reset release, data_input=0, wr_ready=1 -> 16 writes addr 0..15 data 00, frame_done at cycle 19.
//  2 Set byte5=8'h31, byte6=8'h37 -> rewrite: addr5=31, addr6=37, all other cells 00, 16 writes.
//  3 wr_ready low 3 cycles on addr 7 -> wr_en/addr/data held 3 cycles, addr7 written once.
//  4 Change data_input twice while busy -> exactly one extra frame, containing the second value.
//  5 Assert rst_n=0 at addr 9 -> wr_en=0 asynchronously; after release full frame from addr 0.
//  6 REFRESH_CYC=50, data static -> frame rewritten every 50 cycles, frame_done pulse each time.

Source files
------------

// File: rtl/frame_ram_writer_pkg.sv
// Shared constants and state type for the frame RAM writer.
package frame_ram_writer_pkg;

  // Frame geometry of the game-mode frame bus.
  localparam int FRAME_BYTES = 16;
  localparam int FONT_W      = 8;
  localparam int FRAME_W     = FRAME_BYTES * FONT_W;

  // Writer sequencing: wait for work, snapshot, stream bytes, report completion.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

endpackage

// File: rtl/frame_ram_writer_refresh_timer.sv
// Free-running period counter that produces a one-cycle refresh tick.
module frame_ram_writer_refresh_timer #(
  parameter int PERIOD = 50
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count 0..PERIOD-1 and wrap.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  assign tick_o = (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_ram_writer.sv
// Snapshots the game-mode frame whenever it changes (or on refresh) and
// streams it byte by byte into the display RAM over a valid/ready port.
module frame_ram_writer
  import frame_ram_writer_pkg::*;
#(
  parameter int NUM_BYTES   = FRAME_BYTES,
  parameter int BYTE_W      = FONT_W,
  parameter int ADDR_W      = 4,
  parameter int REFRESH_CYC = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_BYTES*BYTE_W-1:0] data_input,
  input  logic                        wr_ready,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [BYTE_W-1:0]           wr_data,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int              DW       = NUM_BYTES * BYTE_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

  wr_state_e         state_q, state_d;
  logic [DW-1:0]     snapshot_q, snapshot_d;
  logic [DW-1:0]     last_frame_q, last_frame_d;
  logic              dirty_q, dirty_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              refresh_tick;
  logic [ADDR_W-1:0] next_addr;
  logic [BYTE_W-1:0] snap_bytes [NUM_BYTES];

  // Byte i of the frame lives at the top end: cell 0 is the MSB byte.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_unpack
    assign snap_bytes[gi] = snapshot_q[DW-1-gi*BYTE_W -: BYTE_W];
  end

  // Optional periodic forced rewrite.
  if (REFRESH_CYC > 0) begin : g_refresh
    frame_ram_writer_refresh_timer #(
      .PERIOD (REFRESH_CYC)
    ) u_refresh_timer (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .tick_o  (refresh_tick)
    );
  end else begin : g_no_refresh
    assign refresh_tick = 1'b0;
  end

  assign next_addr = wr_addr_q + 1'b1;

  // Next-state and registered-output logic for the write sequencer.
  always_comb begin
    state_d      = state_q;
    snapshot_d   = snapshot_q;
    last_frame_d = last_frame_q;
    dirty_d      = dirty_q;
    wr_en_d      = wr_en_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    // A tick outside LOAD is remembered; one in LOAD is served by that load.
    if (refresh_tick) begin
      dirty_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (dirty_q || (data_input != last_frame_q) || refresh_tick) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        snapshot_d   = data_input;
        last_frame_d = data_input;
        dirty_d      = 1'b0;
        busy_d       = 1'b1;
        wr_en_d      = 1'b1;
        wr_addr_d    = '0;
        wr_data_d    = data_input[DW-1 -: BYTE_W];
        state_d      = ST_WRITE;
      end
      ST_WRITE: begin
        if (wr_en_q && wr_ready) begin
          if (wr_addr_q == LAST_IDX) begin
            wr_en_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            wr_addr_d = next_addr;
            wr_data_d = snap_bytes[next_addr];
          end
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset forces a full rewrite afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      snapshot_q   <= '0;
      last_frame_q <= '0;
      dirty_q      <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snapshot_q   <= snapshot_d;
      last_frame_q <= last_frame_d;
      dirty_q      <= dirty_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_ram_writer.sv
// Scoreboard bench for frame_ram_writer: expected frames are queued by the
// stimulus, a monitor pops and compares every accepted RAM write.
module tb_frame_ram_writer;

  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst_n, rst_r_n;
  logic [127:0] data_input, data_r;
  logic         wr_ready, wr_ready_r;
  logic         wr_en, busy, frame_done;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         wr_en_r, busy_r, frame_done_r;
  logic [3:0]   wr_addr_r;
  logic [7:0]   wr_data_r;

  always #5 clk = ~clk;

  frame_ram_writer #(.NUM_BYTES(16), .BYTE_W(8), .ADDR_W(4), .REFRESH_CYC(0)) dut (
    .clk(clk), .rst_n(rst_n), .data_input(data_input), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done)
  );

  frame_ram_writer #(.NUM_BYTES(16), .BYTE_W(8), .ADDR_W(4), .REFRESH_CYC(50)) dut_r (
    .clk(clk), .rst_n(rst_r_n), .data_input(data_r), .wr_ready(wr_ready_r),
    .wr_en(wr_en_r), .wr_addr(wr_addr_r), .wr_data(wr_data_r), .busy(busy_r),
    .frame_done(frame_done_r)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  int done_cnt = 0;
  int rdone = 0;

  // Stimulus-owned controls for the ready driver.
  bit   rand_ready = 0;
  int   stall_left = 0;
  int   stall_applied = 0;
  logic [3:0] stall_addr = 4'd0;
  logic [127:0] model_last;

  function automatic logic [7:0] byte_of(input logic [127:0] f, input int i);
    return f[127-8*i -: 8];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One cycle: wait for the falling edge, then drive wr_ready for the next edge.
  task automatic step();
    @(negedge clk);
    if (stall_left > 0 && wr_en && wr_addr == stall_addr) begin
      wr_ready = 1'b0;
      stall_left--;
      stall_applied++;
    end else if (rand_ready) begin
      wr_ready = ($urandom_range(0, 3) != 0);
    end else begin
      wr_ready = 1'b1;
    end
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < 3 && n < 3000) begin
      step();
      n++;
      if (!busy && !wr_en) q++;
      else q = 0;
    end
    if (q < 3) check("quiet_timeout", 0, 1);
  endtask

  task automatic issue(input logic [127:0] f);
    data_input = f;
    if (f != model_last) begin
      exp_q.push_back(f);
      model_last = f;
    end
  endtask

  function automatic logic [127:0] rand_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor for the main instance: every accepted write is checked in order.
  initial begin : monitor
    logic [127:0] cur;
    bit           active;
    int           idx;
    bit           hold_pend;
    logic [3:0]   hold_addr;
    logic [7:0]   hold_data;
    active = 0; idx = 0; hold_pend = 0; cur = '0; hold_addr = '0; hold_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        active = 0; idx = 0; hold_pend = 0;
        continue;
      end
      if (hold_pend) begin
        check("hold_wr_en", wr_en, 1);
        check("hold_wr_addr", wr_addr, hold_addr);
        check("hold_wr_data", wr_data, hold_data);
        hold_pend = 0;
      end
      if (wr_en) begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            check("spurious_frame", 1, 0);
            cur = data_input;
          end else begin
            cur = exp_q.pop_front();
          end
          active = 1;
          idx = 0;
        end
        if (wr_ready) begin
          check("wr_addr", wr_addr, idx);
          check("wr_data", wr_data, byte_of(cur, idx));
          idx++;
        end else begin
          hold_pend = 1;
          hold_addr = wr_addr;
          hold_data = wr_data;
        end
      end
      if (frame_done) begin
        check("done_byte_count", idx, NB);
        check("done_busy_low", busy, 0);
        $display("frame %0d written: %h (%0d bytes)", done_cnt, cur, idx);
        done_cnt++;
        active = 0;
        idx = 0;
      end
    end
  end

  // Monitor for the refresh instance: static data, rewritten every 50 cycles.
  initial begin : refresh_monitor
    int cyc;
    int last_done;
    int ridx;
    cyc = 0; last_done = 0; ridx = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_r_n) begin
        cyc = 0; ridx = 0;
        continue;
      end
      cyc++;
      if (wr_en_r && wr_ready_r) begin
        check("r_wr_addr", wr_addr_r, ridx);
        check("r_wr_data", wr_data_r, byte_of(data_r, ridx));
        ridx++;
      end
      if (frame_done_r) begin
        rdone++;
        check("r_byte_count", ridx, NB);
        if (rdone >= 3) check("r_refresh_period", cyc - last_done, 50);
        $display("refresh frame %0d done at cycle %0d", rdone, cyc);
        last_done = cyc;
        ridx = 0;
      end
    end
  end

  initial begin : stimulus
    logic [127:0] f;
    int k;
    int d0;
    bit found;
    rst_n = 1'b0; rst_r_n = 1'b0;
    data_input = '0; wr_ready = 1'b1;
    data_r = 128'h00112233445566778899AABBCCDDEEFF;
    wr_ready_r = 1'b1;
    model_last = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);

    // 1: all-zero frame still written after reset; frame_done 19 cycles later.
    exp_q.push_back('0);
    rst_n = 1'b1; rst_r_n = 1'b1;
    k = 0; found = 0;
    while (k < 40 && !found) begin
      step();
      k++;
      if (frame_done) found = 1;
    end
    check("t1_done_latency", k, 19);

    // 2: two cells changed.
    wait_quiet();
    f = '0;
    f[127-8*5 -: 8] = 8'h31;
    f[127-8*6 -: 8] = 8'h37;
    issue(f);

    // 3: three stall cycles on address 7.
    wait_quiet();
    stall_addr = 4'd7; stall_left = 3; stall_applied = 0;
    issue(rand_frame());
    wait_quiet();
    check("t3_stall_cycles", stall_applied, 3);

    // 4: two changes while busy -> one extra frame with the latest value.
    wait_quiet();
    d0 = done_cnt;
    issue(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    k = 0;
    while (!busy && k < 20) begin step(); k++; end
    check("t4_busy_seen", busy, 1);
    repeat (3) step();
    data_input = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    repeat (3) step();
    issue(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    wait_quiet();
    check("t4_frame_count", done_cnt - d0, 2);

    // 5: reset mid-frame at address 9, then a full rewrite.
    wait_quiet();
    f = rand_frame();
    issue(f);
    k = 0;
    while (!(wr_en && wr_addr == 4'd9) && k < 100) begin step(); k++; end
    check("t5_reached_addr9", wr_addr, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_wr_en", wr_en, 0);
    check("t5_async_busy", busy, 0);
    step(); step();
    exp_q.push_back(f);
    rst_n = 1'b1;
    wait_quiet();

    // Randomized frames with random backpressure; some unchanged frames.
    for (int i = 0; i < 25; i++) begin
      wait_quiet();
      rand_ready = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: f = model_last;
        1: begin
          f = model_last;
          f[127-8*$urandom_range(0, 15) -: 8] = 8'($urandom);
        end
        default: f = rand_frame();
      endcase
      issue(f);
    end
    wait_quiet();
    rand_ready = 0;

    check("queue_empty", exp_q.size(), 0);
    check("r_enough_refreshes", rdone >= 5, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
